// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Multi-cycle N-bit subtractor computing A - B - BIN by
//                chaining a DIGIT-bit subtract stage over WIDTH/DIGIT cycles,
//                LSB digit first. Produces the difference plus borrow-out,
//                signed overflow and zero flags behind a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(STEPS - 1);

    // Reject parameter sets that cannot be chained into whole digits.
    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $error("serial_subtractor: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // One digit of subtraction in DIGIT+1 bits; the top bit is the borrow out.
    logic [DIGIT:0]   w_step;
    logic [DIGIT-1:0] w_digit;
    logic             w_borrow;
    logic [WIDTH-1:0] w_res_shift;
    logic             w_ovf;

    assign w_step      = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
                         - (DIGIT+1)'(borrow_q);
    assign w_digit     = w_step[DIGIT-1:0];
    assign w_borrow    = w_step[DIGIT];
    // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
    assign w_res_shift = (res_q >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));
    // Sign bits are captured at accept time because the operand registers shift.
    assign w_ovf       = (a_msb_q ^ b_msb_q) & (w_res_shift[WIDTH-1] ^ a_msb_q);

    // Next-state and datapath update; result flags only load on the final digit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    borrow_d = bin_i;
                    a_msb_d  = a_i[WIDTH-1];
                    b_msb_d  = b_i[WIDTH-1];
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                res_d    = w_res_shift;
                borrow_d = w_borrow;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    diff_d  = w_res_shift;
                    bout_d  = w_borrow;
                    ovf_d   = w_ovf;
                    zero_d  = ~|w_res_shift;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight and clears results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;

endmodule
`default_nettype wire
